// File: rtl/reset_pkg.sv
// Shared types and helpers for the staged reset sequencer and its reset domains.
package reset_pkg;

  localparam int unsigned DefStageDelay = 1024;
  localparam int unsigned DefTimeout    = 65536;

  typedef enum logic [2:0] {
    StHold,
    StRelease,
    StWaitRdy,
    StGap,
    StDone,
    StFault
  } seq_state_e;

  // Index width for a stage count; never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reset_sync.sv
// Two-flop reset synchronizer: asserts asynchronously, deasserts on the second clk edge.
module reset_sync (
  input  logic clk,
  input  logic rst_n,
  output logic rst_sync_n
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= 1'b1;
      sync_q <= meta_q;
    end
  end

  assign rst_sync_n = sync_q;

endmodule

// File: rtl/reset_sequencer.sv
// Releases downstream reset domains one at a time, waiting for each to acknowledge ready,
// and re-holds the whole chain if a stage times out or drops its ready.
module reset_sequencer
  import reset_pkg::*;
#(
  parameter int unsigned N_STAGES    = 3,
  parameter int unsigned STAGE_DELAY = DefStageDelay,
  parameter int unsigned TIMEOUT     = DefTimeout,
  parameter int unsigned CNT_W       = 32,
  localparam int unsigned IDX_W      = idx_w(N_STAGES)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                soft_rst_req,
  input  logic [N_STAGES-1:0] stage_ready,
  output logic [N_STAGES-1:0] stage_rst,
  output logic                all_ready,
  output logic                busy,
  output logic                err,
  output logic [IDX_W-1:0]    err_stage
);

  localparam logic [CNT_W-1:0] DelayLast   = CNT_W'(STAGE_DELAY - 1);
  localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IdxLast     = IDX_W'(N_STAGES - 1);

  logic rst_sync_n;

  reset_sync u_reset_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .rst_sync_n (rst_sync_n)
  );

  seq_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [N_STAGES-1:0] stage_rst_q, stage_rst_d;
  logic                all_ready_q, all_ready_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;
  logic [IDX_W-1:0]    err_stage_q, err_stage_d;

  logic                drop_any;
  logic [IDX_W-1:0]    drop_idx;

  // Lowest released stage whose ready has fallen; unreleased stages are ignored.
  always_comb begin
    drop_any = 1'b0;
    drop_idx = '0;
    for (int j = N_STAGES - 1; j >= 0; j--) begin
      if (!stage_ready[j] && (state_q == StDone || j < int'(idx_q))) begin
        drop_any = 1'b1;
        drop_idx = IDX_W'(j);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    stage_rst_d = stage_rst_q;
    err_d       = err_q;
    err_stage_d = err_stage_q;

    if (soft_rst_req || !rst_sync_n) begin
      state_d     = StHold;
      cnt_d       = '0;
      idx_d       = '0;
      stage_rst_d = '1;
      err_d       = 1'b0;
      err_stage_d = '0;
    end else begin
      unique case (state_q)
        StHold: begin
          if (cnt_q == DelayLast) begin
            cnt_d   = '0;
            idx_d   = '0;
            state_d = StRelease;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StRelease: begin
          stage_rst_d[idx_q] = 1'b0;
          cnt_d              = '0;
          state_d            = StWaitRdy;
        end
        StWaitRdy: begin
          if (drop_any) begin
            state_d     = StFault;
            err_stage_d = drop_idx;
          end else if (stage_ready[idx_q]) begin
            // Ready is checked before the timeout so a same-cycle ack still succeeds.
            if (idx_q == IdxLast) begin
              state_d = StDone;
            end else begin
              state_d = StGap;
              cnt_d   = '0;
            end
          end else if (cnt_q == TimeoutLast) begin
            state_d     = StFault;
            err_stage_d = idx_q;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StGap: begin
          if (drop_any) begin
            state_d     = StFault;
            err_stage_d = drop_idx;
          end else if (cnt_q == DelayLast) begin
            cnt_d   = '0;
            idx_d   = idx_q + 1'b1;
            state_d = StRelease;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StDone: begin
          if (drop_any) begin
            state_d     = StFault;
            err_stage_d = drop_idx;
          end
        end
        StFault: begin
          state_d = StFault;
        end
        default: begin
          state_d = StHold;
        end
      endcase

      if (state_d == StFault) begin
        stage_rst_d = '1;
        err_d       = 1'b1;
      end
    end

    all_ready_d = (state_d == StDone);
    busy_d      = !(state_d inside {StDone, StFault});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StHold;
      cnt_q       <= '0;
      idx_q       <= '0;
      stage_rst_q <= '1;
      all_ready_q <= 1'b0;
      busy_q      <= 1'b1;
      err_q       <= 1'b0;
      err_stage_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      stage_rst_q <= stage_rst_d;
      all_ready_q <= all_ready_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      err_stage_q <= err_stage_d;
    end
  end

  assign stage_rst = stage_rst_q;
  assign all_ready = all_ready_q;
  assign busy      = busy_q;
  assign err       = err_q;
  assign err_stage = err_stage_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with N_STAGES=3, STAGE_DELAY=4, TIMEOUT=8.
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       soft_rst_req;
  logic [2:0] stage_ready = '0;
  logic [2:0] stage_rst;
  logic       all_ready;
  logic       busy;
  logic       err;
  logic [1:0] err_stage;

  logic [2:0] ready_en = 3'b111;
  logic [2:0] rel_pipe = '0;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int         k;
    logic [2:0] rst;
    logic       ar;
    logic       bsy;
  } vec_t;

  vec_t tbl[10];

  reset_sequencer #(
    .N_STAGES    (3),
    .STAGE_DELAY (4),
    .TIMEOUT     (8),
    .CNT_W       (32)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .soft_rst_req (soft_rst_req),
    .stage_ready  (stage_ready),
    .stage_rst    (stage_rst),
    .all_ready    (all_ready),
    .busy         (busy),
    .err          (err),
    .err_stage    (err_stage)
  );

  always #5 clk = ~clk;

  // Each stage acks ready one cycle after its reset falls, unless masked off by ready_en.
  always @(posedge clk) begin
    #1;
    stage_ready = rel_pipe & ready_en;
    rel_pipe    = ~stage_rst;
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [2:0] e_rst, input logic e_ar,
                            input logic e_busy, input logic e_err, input logic [1:0] e_es);
    check({tag, ".stage_rst"}, 8'(stage_rst), 8'(e_rst));
    check({tag, ".all_ready"}, 8'(all_ready), 8'(e_ar));
    check({tag, ".busy"},      8'(busy),      8'(e_busy));
    check({tag, ".err"},       8'(err),       8'(e_err));
    check({tag, ".err_stage"}, 8'(err_stage), 8'(e_es));
  endtask

  // k counts edges after the reference edge (second edge after rst_n rise, or the soft edge).
  task automatic run_table(input string tag);
    int k = 0;
    foreach (tbl[i]) begin
      while (k < tbl[i].k) begin
        tick();
        k++;
      end
      check_outs($sformatf("%s.k%0d", tag, tbl[i].k), tbl[i].rst, tbl[i].ar, tbl[i].bsy,
                 1'b0, 2'd0);
    end
  endtask

  task automatic soft_pulse();
    soft_rst_req = 1'b1;
    tick();
    soft_rst_req = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{k: 0,  rst: 3'b111, ar: 1'b0, bsy: 1'b1};
    tbl[1] = '{k: 1,  rst: 3'b111, ar: 1'b0, bsy: 1'b1};
    tbl[2] = '{k: 4,  rst: 3'b111, ar: 1'b0, bsy: 1'b1};
    tbl[3] = '{k: 5,  rst: 3'b110, ar: 1'b0, bsy: 1'b1};
    tbl[4] = '{k: 11, rst: 3'b110, ar: 1'b0, bsy: 1'b1};
    tbl[5] = '{k: 12, rst: 3'b100, ar: 1'b0, bsy: 1'b1};
    tbl[6] = '{k: 18, rst: 3'b100, ar: 1'b0, bsy: 1'b1};
    tbl[7] = '{k: 19, rst: 3'b000, ar: 1'b0, bsy: 1'b1};
    tbl[8] = '{k: 20, rst: 3'b000, ar: 1'b0, bsy: 1'b1};
    tbl[9] = '{k: 21, rst: 3'b000, ar: 1'b1, bsy: 1'b0};

    rst_n        = 1'b0;
    soft_rst_req = 1'b0;
    repeat (3) @(negedge clk);
    check_outs("reset", 3'b111, 1'b0, 1'b1, 1'b0, 2'd0);

    // Nominal power-up sequence.
    rst_n = 1'b1;
    tick();
    tick();
    run_table("nominal");

    // One-cycle ready drop in DONE on stage 0.
    ready_en = 3'b110;
    tick();
    check_outs("drop_pre", 3'b000, 1'b1, 1'b0, 1'b0, 2'd0);
    tick();
    check_outs("drop_fault", 3'b111, 1'b0, 1'b0, 1'b1, 2'd0);
    ready_en = 3'b111;
    repeat (3) tick();
    check_outs("fault_hold", 3'b111, 1'b0, 1'b0, 1'b1, 2'd0);

    // Soft reset out of FAULT replays the nominal timing.
    soft_pulse();
    run_table("soft");

    // Asynchronous reset in the gap between stage 1 and stage 2.
    soft_pulse();
    repeat (15) tick();
    check_outs("gap_pre", 3'b100, 1'b0, 1'b1, 1'b0, 2'd0);
    rst_n = 1'b0;
    #1;
    check_outs("async", 3'b111, 1'b0, 1'b1, 1'b0, 2'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    run_table("async_restart");

    // Stage 1 never acks: timeout eight edges after entering WAIT_RDY.
    ready_en = 3'b101;
    soft_pulse();
    repeat (19) tick();
    check_outs("timeout_pre", 3'b100, 1'b0, 1'b1, 1'b0, 2'd0);
    tick();
    check_outs("timeout", 3'b111, 1'b0, 1'b0, 1'b1, 2'd1);
    ready_en = 3'b111;

    // Stage 2 acks on the very cycle the timeout would fire.
    ready_en = 3'b011;
    soft_pulse();
    repeat (25) tick();
    ready_en = 3'b111;
    tick();
    check_outs("race_pre", 3'b000, 1'b0, 1'b1, 1'b0, 2'd0);
    tick();
    check_outs("race_done", 3'b000, 1'b1, 1'b0, 1'b0, 2'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
